// File: rtl/ksz_bus_arbiter.sv
// ksz_bus_arbiter
// Two-port arbiter and strobe sequencer for the KSZ8851 16-bit host bus.
// Port 0 carries initialization/configuration traffic, port 1 the packet path.
// Each granted transaction runs SETUP -> STROBE -> HOLD, with the cycle count
// of each phase set by a parameter, and returns a one-cycle ackN.
//
// Build option: define KSZ_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// When it is undefined, port 0 has fixed priority over port 1.
//
// Ports
//   clk40m, reset          sole clock; synchronous active-high reset
//   reqN/lockN/cmdN/wrN    per-port request, ownership lock, CMD value, write flag
//   wdataN / rdataN        per-port write data / read data (rdata valid from ackN)
//   ackN                   one-cycle completion pulse (final HOLD cycle)
//   CMD, RDN, WRN, SD      controller pins; SD is driven only during writes
//   busy, owner            transaction in flight; current/last granted port
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | bus released, evaluate requests
// ST_SETUP   | CMD (and SD on writes) valid, strobes high
// ST_STROBE  | RDN or WRN low; read data captured in the last cycle
// ST_HOLD    | strobes high, write data still driven; ack in last cycle
module ksz_bus_arbiter #(
   parameter int unsigned SETUP_CYCLES  = 1,
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned HOLD_CYCLES   = 1
) (
   input  logic        clk40m,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        lock0,
   input  logic        lock1,
   input  logic        cmd0,
   input  logic        cmd1,
   input  logic        wr0,
   input  logic        wr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [15:0] rdata0,
   output logic [15:0] rdata1,
   output logic        CMD,
   output logic        RDN,
   output logic        WRN,
   inout  tri   [15:0] SD,
   output logic        busy,
   output logic        owner
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

   localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        cmd_q, cmd_d;
   logic        wr_q, wr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        sd_oe_q, sd_oe_d;
   logic        rdn_q, rdn_d;
   logic        wrn_q, wrn_d;
   logic        busy_q, busy_d;
   logic        owner_q, owner_d;
   logic        lock_q, lock_d;
   logic        rr_q, rr_d;
   logic [1:0]  ack_q, ack_d;
   logic [15:0] capture_q, capture_d;
   logic [15:0] rdata0_q, rdata0_d;
   logic [15:0] rdata1_q, rdata1_d;

   logic        grant;
   logic        win;
   logic        ack_now;
   logic [15:0] rd_val;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      owner_d   = owner_q;
      lock_d    = lock_q;
      rr_d      = rr_q;
      capture_d = capture_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      ack_d     = 2'b00;
      grant     = 1'b0;
      win       = 1'b0;
      ack_now   = 1'b0;
      // With a single HOLD cycle the ack edge is also the capture edge, so
      // take read data straight off the pins instead of the capture register.
      rd_val    = (state_q == ST_STROBE) ? SD : capture_q;

      case (state_q)
         ST_IDLE: begin
            if (lock_q) begin
               // Bus parked on the owner: the other port waits even if the
               // owner has no request this cycle.
               grant = owner_q ? req1 : req0;
               win   = owner_q;
            end else if (req0 && req1) begin
               grant = 1'b1;
`ifdef KSZ_ARB_ROUND_ROBIN_EN
               win   = ~rr_q;
`else
               win   = 1'b0;
`endif
            end else if (req0 || req1) begin
               grant = 1'b1;
               win   = req1;
            end
            if (grant) begin
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
               cmd_d   = win ? cmd1 : cmd0;
               wr_d    = win ? wr1 : wr0;
               wdata_d = win ? wdata1 : wdata0;
               owner_d = win;
               rr_d    = win;
            end
         end
         ST_SETUP: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
               if (!wr_q) capture_d = SD;
               ack_now = (HOLD_CYCLES == 1);
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_IDLE;
               lock_d  = owner_q ? lock1 : lock0;
            end else begin
               cnt_d   = cnt_q - 8'd1;
               ack_now = (cnt_q == 8'd1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // ack and rdata are registered on the edge that enters the final HOLD cycle.
      if (ack_now) begin
         ack_d[owner_q] = 1'b1;
         if (!wr_q) begin
            if (owner_q) rdata1_d = rd_val;
            else         rdata0_d = rd_val;
         end
      end

      // Pin outputs are registered from the next state so they change on the
      // same edge as the phase.
      busy_d  = (state_d != ST_IDLE);
      sd_oe_d = (state_d != ST_IDLE) && wr_d;
      rdn_d   = !((state_d == ST_STROBE) && !wr_d);
      wrn_d   = !((state_d == ST_STROBE) && wr_d);
   end

   always_ff @(posedge clk40m) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         cmd_q     <= 1'b0;
         wr_q      <= 1'b0;
         wdata_q   <= 16'd0;
         sd_oe_q   <= 1'b0;
         rdn_q     <= 1'b1;
         wrn_q     <= 1'b1;
         busy_q    <= 1'b0;
         owner_q   <= 1'b0;
         lock_q    <= 1'b0;
         rr_q      <= 1'b1;
         ack_q     <= 2'b00;
         capture_q <= 16'd0;
         rdata0_q  <= 16'd0;
         rdata1_q  <= 16'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         sd_oe_q   <= sd_oe_d;
         rdn_q     <= rdn_d;
         wrn_q     <= wrn_d;
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         lock_q    <= lock_d;
         rr_q      <= rr_d;
         ack_q     <= ack_d;
         capture_q <= capture_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign SD     = sd_oe_q ? wdata_q : 16'bz;
   assign CMD    = cmd_q;
   assign RDN    = rdn_q;
   assign WRN    = wrn_q;
   assign busy   = busy_q;
   assign owner  = owner_q;
   assign ack0   = ack_q[0];
   assign ack1   = ack_q[1];
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_ksz_bus_arbiter.sv
module tb_ksz_bus_arbiter;

`ifdef KSZ_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk40m = 1'b0;
   logic        reset  = 1'b1;
   logic        req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
   logic        cmd0 = 0, cmd1 = 0, wr0 = 0, wr1 = 0;
   logic [15:0] wdata0 = 0, wdata1 = 0;
   logic        ack0, ack1, CMD, RDN, WRN, busy, owner;
   logic [15:0] rdata0, rdata1;
   wire  [15:0] sd;

   // Bus model: when enabled it drives 0xA5A5 while RDN is low and a
   // 0x5A5A marker otherwise, so any DUT drive on SD shows up as a corrupted value.
   logic        tb_drv_en = 1'b1;
   assign sd = tb_drv_en ? (RDN ? 16'h5A5A : 16'hA5A5) : 16'bz;

   int errors = 0;
   int checks = 0;

   always #5 clk40m = ~clk40m;

   ksz_bus_arbiter dut (
      .clk40m(clk40m), .reset(reset),
      .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
      .cmd0(cmd0), .cmd1(cmd1), .wr0(wr0), .wr1(wr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .CMD(CMD), .RDN(RDN), .WRN(WRN), .SD(sd),
      .busy(busy), .owner(owner)
   );

   task automatic tick();
      @(posedge clk40m);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   initial begin
      int n;
      logic [15:0] exp_p;

      // Reset values
      tick(); tick();
      chk("rst_cmd", CMD, 0);      chk("rst_rdn", RDN, 1);
      chk("rst_wrn", WRN, 1);      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);    chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0); chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);  chk("rst_sd_hiz", sd, 16'h5A5A);
      reset = 1'b0;
      tick();

      // Write on port 0
      tb_drv_en = 1'b0;
      req0 = 1; cmd0 = 1; wr0 = 1; wdata0 = 16'h0011;
      tick();
      chk("w_setup_busy", busy, 1); chk("w_setup_cmd", CMD, 1);
      chk("w_setup_sd", sd, 16'h0011); chk("w_setup_wrn", WRN, 1);
      chk("w_setup_rdn", RDN, 1); chk("w_setup_ack", ack0, 0);
      tick();
      chk("w_strb1_wrn", WRN, 0); chk("w_strb1_sd", sd, 16'h0011); chk("w_strb1_cmd", CMD, 1);
      tick();
      chk("w_strb2_wrn", WRN, 0); chk("w_strb2_ack", ack0, 0);
      tick();
      chk("w_hold_wrn", WRN, 1); chk("w_hold_ack0", ack0, 1);
      chk("w_hold_sd", sd, 16'h0011); chk("w_hold_cmd", CMD, 1);
      chk("w_hold_ack1", ack1, 0);
      req0 = 0; cmd0 = 0; wr0 = 0;
      tick();
      chk("w_idle_ack0", ack0, 0); chk("w_idle_busy", busy, 0);
      tb_drv_en = 1'b1;
      #1;
      chk("w_idle_sd_hiz", sd, 16'h5A5A);

      // Read on port 1
      req1 = 1; cmd1 = 0; wr1 = 0;
      tick();
      chk("r_setup_owner", owner, 1); chk("r_setup_busy", busy, 1);
      chk("r_setup_rdn", RDN, 1); chk("r_setup_sd", sd, 16'h5A5A); chk("r_setup_cmd", CMD, 0);
      tick();
      chk("r_strb1_rdn", RDN, 0); chk("r_strb1_sd", sd, 16'hA5A5); chk("r_strb1_wrn", WRN, 1);
      tick();
      chk("r_strb2_rdn", RDN, 0);
      tick();
      chk("r_hold_rdn", RDN, 1); chk("r_hold_ack1", ack1, 1);
      chk("r_hold_rdata1", rdata1, 16'hA5A5); chk("r_hold_sd", sd, 16'h5A5A);
      chk("r_hold_rdata0", rdata0, 0);
      req1 = 0;
      tick();
      chk("r_idle_ack1", ack1, 0); chk("r_idle_busy", busy, 0);

      // Both ports requesting continuously: four back-to-back reads
      req0 = 1; cmd0 = 1; wr0 = 0;
      req1 = 1; cmd1 = 0; wr1 = 0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         do begin tick(); n++; end while (!(ack0 || ack1) && n < 8);
         exp_p = RR ? 16'(i % 2) : 16'd0;
         chk($sformatf("b2b%0d_ack_seen", i), {15'd0, ack0 | ack1}, 1);
         chk($sformatf("b2b%0d_ack1", i), ack1, exp_p);
         chk($sformatf("b2b%0d_owner", i), owner, exp_p);
         chk($sformatf("b2b%0d_latency", i), 16'(n), (i == 0) ? 16'd4 : 16'd5);
      end
      req0 = 0; req1 = 0;
      tick();
      chk("b2b_rdata0", rdata0, 16'hA5A5);

      // Lock: command write then data read on port 0 while port 1 waits
      tb_drv_en = 1'b0;
      req1 = 1; cmd1 = 0; wr1 = 0;
      req0 = 1; cmd0 = 1; wr0 = 1; wdata0 = 16'h0022; lock0 = 1;
      n = 0;
      do begin tick(); n++; end while (!(ack0 || ack1) && n < 8);
      chk("lk_cmd_ack0", ack0, 1); chk("lk_cmd_ack1", ack1, 0);
      tick();
      cmd0 = 0; wr0 = 0; lock0 = 0; tb_drv_en = 1'b1;
      tick();
      chk("lk_data_owner", owner, 0); chk("lk_data_busy", busy, 1); chk("lk_data_cmd", CMD, 0);
      n = 0;
      do begin tick(); n++; end while (!(ack0 || ack1) && n < 8);
      chk("lk_data_ack0", ack0, 1); chk("lk_data_ack1", ack1, 0);
      chk("lk_data_rdata0", rdata0, 16'hA5A5);
      req0 = 0;
      n = 0;
      do begin tick(); n++; end while (!(ack0 || ack1) && n < 10);
      chk("lk_p1_ack1", ack1, 1); chk("lk_p1_ack0", ack0, 0); chk("lk_p1_owner", owner, 1);
      chk("lk_p1_latency", 16'(n), 16'd5);
      req1 = 0;
      tick();

      // Reset in the second STROBE cycle of a write
      tb_drv_en = 1'b0;
      req0 = 1; cmd0 = 1; wr0 = 1; wdata0 = 16'h0033;
      tick(); tick(); tick();
      chk("rm_strb2_wrn", WRN, 0);
      reset = 1'b1;
      tick();
      chk("rm_wrn", WRN, 1); chk("rm_busy", busy, 0); chk("rm_ack0", ack0, 0);
      chk("rm_rdn", RDN, 1); chk("rm_cmd", CMD, 0);
      tb_drv_en = 1'b1;
      #1;
      chk("rm_sd_hiz", sd, 16'h5A5A);
      tb_drv_en = 1'b0;
      reset = 1'b0;
      wdata0 = 16'h0044;
      n = 0;
      do begin tick(); n++; end while (!(ack0 || ack1) && n < 8);
      chk("rm_after_ack0", ack0, 1); chk("rm_after_latency", 16'(n), 16'd4);
      chk("rm_after_sd", sd, 16'h0044);
      req0 = 0; wr0 = 0; cmd0 = 0;
      tick();
      tb_drv_en = 1'b1;
      #1;
      chk("rm_end_sd_hiz", sd, 16'h5A5A); chk("rm_end_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
